// File: rtl/tpu_axil_ctrl_slave.sv
// AXI4-Lite register window for the TPU: control/shape registers, staged weight and
// unified-buffer word writes, start pulse and sticky status reporting.
module tpu_axil_ctrl_slave #(
    parameter int ADDR_W = 5,
    parameter int MEM_AW = 8
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic [ADDR_W-1:0] s00_axi_awaddr,
    input  logic              s00_axi_awvalid,
    output logic              s00_axi_awready,
    input  logic [31:0]       s00_axi_wdata,
    input  logic [3:0]        s00_axi_wstrb,
    input  logic              s00_axi_wvalid,
    output logic              s00_axi_wready,
    output logic [1:0]        s00_axi_bresp,
    output logic              s00_axi_bvalid,
    input  logic              s00_axi_bready,
    input  logic [ADDR_W-1:0] s00_axi_araddr,
    input  logic              s00_axi_arvalid,
    output logic              s00_axi_arready,
    output logic [31:0]       s00_axi_rdata,
    output logic [1:0]        s00_axi_rresp,
    output logic              s00_axi_rvalid,
    input  logic              s00_axi_rready,
    output logic              tick_en,
    output logic              wt_wr_en,
    output logic              ub_wr_en,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mat_start,
    output logic [31:0]       shape_cfg,
    input  logic              tpu_done
);
    localparam int IW = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [IW-1:0] IDX_CTRL   = IW'(0);
    localparam logic [IW-1:0] IDX_WDATA  = IW'(1);
    localparam logic [IW-1:0] IDX_UBDATA = IW'(2);
    localparam logic [IW-1:0] IDX_SHAPE  = IW'(3);
    localparam logic [IW-1:0] IDX_STATUS = IW'(4);

    logic                   wr_acc_q, wr_acc_d, bvalid_q, bvalid_d, arready_q, arready_d;
    logic                   rvalid_q, rvalid_d, busy_q, busy_d, done_q, done_d;
    logic                   seq_err_q, seq_err_d, mat_start_q, mat_start_d;
    logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]            rdata_q, rdata_d, shape_q, shape_d, mem_data_q, mem_data_d;
    logic [3:0]             ctrl_q, ctrl_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic [MEM_AW-1:0]      mem_addr_q, mem_addr_d;
    // Index 0 is the weight FIFO path, index 1 the unified-buffer path.
    logic [1:0]             stg_q, stg_d, wr_en_q, wr_en_d;
    logic [1:0][MEM_AW-1:0] stg_addr_q, stg_addr_d;
    logic [1:0][15:0]       stg_data_q, stg_data_d;

    logic [IW-1:0] wr_idx, rd_idx;
    logic [31:0]   status_w, rd_val;
    logic [1:0]    rd_resp;
    logic          tgt, tgt_en;
    logic          unused_addr_lsbs;

    assign wr_idx   = s00_axi_awaddr[ADDR_W-1:2];
    assign rd_idx   = s00_axi_araddr[ADDR_W-1:2];
    assign status_w = {16'h0, drop_cnt_q, 5'h0, seq_err_q, done_q, busy_q};
    assign unused_addr_lsbs = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    always_comb begin
        // NOTE: every _d gets a default before any branch so no latch is inferred.
        wr_acc_d = s00_axi_awvalid & s00_axi_wvalid & ~wr_acc_q & ~bvalid_q;
        arready_d = s00_axi_arvalid & ~arready_q & ~rvalid_q;
        bvalid_d = bvalid_q & ~s00_axi_bready;
        rvalid_d = rvalid_q & ~s00_axi_rready;
        bresp_d = bresp_q;   rresp_d = rresp_q;   rdata_d = rdata_q;
        ctrl_d = ctrl_q;     shape_d = shape_q;   busy_d = busy_q;
        done_d = done_q;     seq_err_d = seq_err_q;  drop_cnt_d = drop_cnt_q;
        stg_d = stg_q;       stg_addr_d = stg_addr_q; stg_data_d = stg_data_q;
        mem_addr_d = mem_addr_q;  mem_data_d = mem_data_q;
        wr_en_d = 2'b00;     mat_start_d = 1'b0;
        tgt = 1'b0;          tgt_en = 1'b0;
        rd_val = 32'h0;      rd_resp = RESP_OKAY;

        case (rd_idx)
            IDX_CTRL:               rd_val = {28'h0, ctrl_q};
            IDX_WDATA, IDX_UBDATA:  rd_val = 32'h0;
            IDX_SHAPE:              rd_val = shape_q;
            IDX_STATUS:             rd_val = status_w;
            default:                rd_resp = RESP_DECERR;
        endcase
        if (arready_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = rd_resp;
        end

        if (wr_acc_q) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (wr_idx)
                IDX_CTRL: if (s00_axi_wstrb[0]) begin
                    ctrl_d = s00_axi_wdata[3:0];
                    if (s00_axi_wdata[3] && !ctrl_q[3]) begin
                        mat_start_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                    if (!s00_axi_wdata[1]) stg_d[0] = 1'b0;
                    if (!s00_axi_wdata[2]) stg_d[1] = 1'b0;
                end
                IDX_WDATA, IDX_UBDATA: begin
                    tgt    = (wr_idx == IDX_UBDATA);
                    tgt_en = tgt ? ctrl_q[2] : ctrl_q[1];
                    if (s00_axi_wstrb != 4'hF || !tgt_en) begin
                        bresp_d = RESP_SLVERR;
                        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                    end else if (s00_axi_wdata[31]) begin
                        if (stg_q[tgt]) seq_err_d = 1'b1;
                        stg_d[tgt]      = 1'b1;
                        stg_addr_d[tgt] = s00_axi_wdata[16 +: MEM_AW];
                        stg_data_d[tgt] = s00_axi_wdata[15:0];
                    end else if (stg_q[tgt] && stg_addr_q[tgt] == s00_axi_wdata[16 +: MEM_AW]) begin
                        wr_en_d[tgt] = 1'b1;
                        mem_addr_d   = stg_addr_q[tgt];
                        mem_data_d   = {stg_data_q[tgt], s00_axi_wdata[15:0]};
                        stg_d[tgt]   = 1'b0;
                    end else begin
                        seq_err_d  = 1'b1;
                        stg_d[tgt] = 1'b0;
                        bresp_d    = RESP_SLVERR;
                    end
                end
                IDX_SHAPE: for (int b = 0; b < 4; b++)
                    if (s00_axi_wstrb[b]) shape_d[8*b +: 8] = s00_axi_wdata[8*b +: 8];
                IDX_STATUS: if (s00_axi_wstrb[0]) begin
                    if (s00_axi_wdata[1]) done_d    = 1'b0;
                    if (s00_axi_wdata[2]) seq_err_d = 1'b0;
                end
                default: bresp_d = RESP_DECERR;
            endcase
        end

        // Completion outranks a same-cycle W1C of done; a fresh start keeps busy set.
        if (tpu_done) begin
            done_d = 1'b1;
            if (!mat_start_d) busy_d = 1'b0;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock.
        if (!s00_axi_aresetn) begin
            wr_acc_q <= 1'b0;  bvalid_q <= 1'b0;  bresp_q <= 2'b00;
            arready_q <= 1'b0; rvalid_q <= 1'b0;  rresp_q <= 2'b00;  rdata_q <= 32'h0;
            ctrl_q <= 4'h0;    shape_q <= 32'h0;  busy_q <= 1'b0;    done_q <= 1'b0;
            seq_err_q <= 1'b0; drop_cnt_q <= 8'h0;
            stg_q <= '0;       stg_addr_q <= '0;  stg_data_q <= '0;
            wr_en_q <= 2'b00;  mem_addr_q <= '0;  mem_data_q <= 32'h0;  mat_start_q <= 1'b0;
        end else begin
            wr_acc_q <= wr_acc_d;    bvalid_q <= bvalid_d;  bresp_q <= bresp_d;
            arready_q <= arready_d;  rvalid_q <= rvalid_d;  rresp_q <= rresp_d;
            rdata_q <= rdata_d;      ctrl_q <= ctrl_d;      shape_q <= shape_d;
            busy_q <= busy_d;        done_q <= done_d;      seq_err_q <= seq_err_d;
            drop_cnt_q <= drop_cnt_d;
            stg_q <= stg_d;          stg_addr_q <= stg_addr_d;  stg_data_q <= stg_data_d;
            wr_en_q <= wr_en_d;      mem_addr_q <= mem_addr_d;  mem_data_q <= mem_data_d;
            mat_start_q <= mat_start_d;
        end
    end

    assign s00_axi_awready = wr_acc_q;
    assign s00_axi_wready  = wr_acc_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign tick_en   = ctrl_q[0];
    assign wt_wr_en  = wr_en_q[0];
    assign ub_wr_en  = wr_en_q[1];
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mat_start = mat_start_q;
    assign shape_cfg = shape_q;
endmodule
